// File: rtl/esc_pkg.sv
// esc_pkg: shared defaults, pulse-width transfer function and mode encoding for the ESC pulse generators
package esc_pkg;
    localparam int ESC_OFFSET    = 6250;
    localparam int ESC_SCALE     = 3;
    localparam int ESC_SPEED_MAX = 2047;
    localparam int ESC_PERIOD    = 125000;
    typedef enum logic {ESC_ONESHOT = 1'b0, ESC_PERIODIC = 1'b1} esc_mode_e;
    function automatic int unsigned width_clks(input int unsigned offset, input int unsigned scale, input int unsigned spd);
        return offset + scale * spd;
    endfunction
endpackage

// File: rtl/esc_pulse_chan.sv
// esc_pulse_chan: one ESC channel -- clamp, shadow speed, pulse counter and stale-command watchdog
module esc_pulse_chan
    import esc_pkg::*;
#(
    parameter int SPEED_W     = 11,
    parameter int OFFSET      = ESC_OFFSET,
    parameter int SCALE       = ESC_SCALE,
    parameter int SPEED_MAX   = ESC_SPEED_MAX,
    parameter int WDOG_FRAMES = 8,
    parameter int CW          = 17
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [SPEED_W-1:0] speed,
    input  logic               periodic,
    input  logic               arm,
    input  logic               fs,
    output logic               pwm,
    output logic               stale
);
    localparam int WW = $clog2(WDOG_FRAMES + 1);
    localparam logic [SPEED_W-1:0] SMAX = SPEED_W'(SPEED_MAX);
    localparam logic [WW-1:0] WD_LIM = WW'(WDOG_FRAMES);
    logic [SPEED_W-1:0] shadow, clamped, eff;
    logic [CW-1:0] pcnt, width;
    logic [WW-1:0] wcnt;
    logic start;
    // a write on the load edge is used directly, bypassing the shadow
    always_comb begin
        clamped = (speed > SMAX) ? SMAX : speed;
        eff = arm ? (wr ? clamped : shadow) : '0;
        width = CW'(width_clks(OFFSET, SCALE, 32'(eff)));
        start = (esc_mode_e'(periodic) == ESC_PERIODIC) ? fs : wr;
    end
    assign stale = (wcnt == WD_LIM);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            pcnt   <= '0;
            pwm    <= 1'b0;
            wcnt   <= '0;
        end else begin
            pwm    <= start || (pcnt != '0);
            pcnt   <= start ? width - 1 : (pcnt != '0) ? pcnt - 1 : '0;
            wcnt   <= wr ? '0 : (fs && !stale) ? wcnt + 1 : wcnt;
            shadow <= wr ? clamped : (fs && wcnt == WD_LIM - 1) ? '0 : shadow;
        end
    end
endmodule

// File: rtl/esc_multi_interface.sv
// esc_multi_interface: N-channel ESC PWM generator with frame timer, channel decode and per-channel pulse engines
module esc_multi_interface
    import esc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SPEED_W     = 11,
    parameter int OFFSET      = ESC_OFFSET,
    parameter int SCALE       = ESC_SCALE,
    parameter int SPEED_MAX   = ESC_SPEED_MAX,
    parameter int PERIOD      = ESC_PERIOD,
    parameter int WDOG_FRAMES = 8
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrt,
    input  logic [$clog2(NUM_CH)-1:0] ch,
    input  logic [SPEED_W-1:0]        speed,
    input  logic                      periodic,
    input  logic                      arm,
    output logic [NUM_CH-1:0]         pwm,
    output logic                      frame_start,
    output logic [NUM_CH-1:0]         stale
);
    localparam int CW  = $clog2(PERIOD + 1);
    localparam int CHW = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    logic [CW-1:0] fcnt;
    // strobe is registered so it is low out of reset and first fires on the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            fcnt        <= (fcnt == LAST) ? '0 : fcnt + 1;
            frame_start <= (fcnt == LAST);
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pulse_chan #(
            .SPEED_W(SPEED_W), .OFFSET(OFFSET), .SCALE(SCALE),
            .SPEED_MAX(SPEED_MAX), .WDOG_FRAMES(WDOG_FRAMES), .CW(CW)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .wr(wrt && ch == CHW'(i)),
            .speed(speed),
            .periodic(periodic),
            .arm(arm),
            .fs(frame_start),
            .pwm(pwm[i]),
            .stale(stale[i])
        );
    end
endmodule
